// File: rtl/sram_pixel_arbiter.sv
// Arbiter and access sequencer sharing one async 16-bit SRAM between a display
// read port and a capture write port; reads win unless the write has starved.
module sram_pixel_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        wr_be,
   output logic              wr_grant,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_CAP, WR_SET, WR_PULSE, WR_HOLD
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              arb_en;
   logic              write_due;
   logic              pick_rd;
   logic              pick_wr;

   // Arbitration resolves on the edge that enters an IDLE cycle, so the
   // registered grant is visible during that IDLE cycle; while a grant is
   // pending the IDLE cycle must not arbitrate again.
   always_comb begin
      arb_en    = ((state == IDLE) && !rd_grant && !wr_grant) ||
                  (state == RD_CAP) || (state == WR_HOLD);
      write_due = (wait_cnt >= WAIT_LIMIT);
      pick_wr   = arb_en && wr_req && (!rd_req || write_due);
      pick_rd   = arb_en && rd_req && !pick_wr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         rd_grant    <= 1'b0;
         wr_grant    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         busy        <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
      end else begin
         rd_grant <= pick_rd;
         wr_grant <= pick_wr;
         rd_valid <= 1'b0;
         if (pick_wr)
            wait_cnt <= '0;
         else if (pick_rd && wr_req && (wait_cnt != WAIT_SAT))
            wait_cnt <= wait_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (rd_grant) begin
                  state      <= RD_ADDR;
                  busy       <= 1'b1;
                  sram_addr  <= rd_addr;
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= 1'b0;
                  sram_ub_n  <= 1'b0;
                  sram_lb_n  <= 1'b0;
                  sram_dq_oe <= 1'b0;
               end else if (wr_grant) begin
                  state       <= WR_SET;
                  busy        <= 1'b1;
                  sram_addr   <= wr_addr;
                  sram_dq_out <= wr_data;
                  sram_ub_n   <= ~wr_be[1];
                  sram_lb_n   <= ~wr_be[0];
                  sram_ce_n   <= 1'b0;
                  sram_oe_n   <= 1'b1;
                  sram_we_n   <= 1'b1;
                  sram_dq_oe  <= 1'b1;
               end
            end
            RD_ADDR: state <= RD_CAP;
            RD_CAP: begin
               state     <= IDLE;
               busy      <= 1'b0;
               rd_data   <= sram_dq_in;
               rd_valid  <= 1'b1;
               sram_ce_n <= 1'b1;
               sram_oe_n <= 1'b1;
               sram_ub_n <= 1'b1;
               sram_lb_n <= 1'b1;
            end
            WR_SET: begin
               state     <= WR_PULSE;
               sram_we_n <= 1'b0;
            end
            WR_PULSE: begin
               state     <= WR_HOLD;
               sram_we_n <= 1'b1;
            end
            WR_HOLD: begin
               // Dropping dq_oe with ce_n guarantees a dead bus cycle before any read
               state      <= IDLE;
               busy       <= 1'b0;
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_ub_n  <= 1'b1;
               sram_lb_n  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
